// File: rtl/sram_port_adapter.sv
// Valid/ready front end for a single-port SRAM with a credit-protected read response FIFO.
// Read data reaches rsp_* READ_LAT+1 cycles after accept; req_ready_o drops when FIFO credits run out.
module sram_port_adapter #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int NUM_WORDS  = 1024,
    parameter int READ_LAT   = 1,
    parameter int RSP_DEPTH  = 2,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [USER_WIDTH-1:0] req_wuser_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [USER_WIDTH-1:0] rsp_ruser_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [USER_WIDTH-1:0] sram_wuser_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic [USER_WIDTH-1:0] sram_ruser_i
);

    localparam int CW = $clog2(RSP_DEPTH + READ_LAT + 1) + 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    if (READ_LAT < 1 || READ_LAT > 2 || RSP_DEPTH < 1) begin : g_param_check
        $error("sram_port_adapter: READ_LAT must be 1 or 2 and RSP_DEPTH must be >= 1");
    end

    logic [READ_LAT-1:0]   r_pipe;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem_dat [RSP_DEPTH];
    logic [USER_WIDTH-1:0] r_mem_usr [RSP_DEPTH];

    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_occ;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_issue_rd;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    // Every accepted read owns a FIFO slot from accept until pop; a same-cycle pop frees one early.
    assign rsp_valid_o = (r_count != '0);
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign w_push      = r_pipe[READ_LAT-1];
    assign w_occ       = r_count + w_inflight - CW'(w_pop);
    assign req_ready_o = (w_occ < CW'(RSP_DEPTH));
    assign w_issue     = req_valid_i & req_ready_o;
    assign w_issue_rd  = w_issue & ~req_we_i;

    assign sram_req_o   = w_issue;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_wuser_o = req_wuser_i;
    assign sram_be_o    = req_we_i ? req_be_i : '0;

    assign rsp_rdata_o = r_mem_dat[r_rd_ptr];
    assign rsp_ruser_o = r_mem_usr[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe   <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem_dat[i] <= '0;
                r_mem_usr[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_push) begin
                r_mem_dat[r_wr_ptr] <= sram_rdata_i;
                r_mem_usr[r_wr_ptr] <= sram_ruser_i;
                r_wr_ptr <= (r_wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_push && !w_pop) |-> (r_count != CW'(RSP_DEPTH)))
        else $error("sram_port_adapter: response FIFO overflow");

endmodule

// File: tb/tb_sram_port_adapter.sv
// Bench for sram_port_adapter: two instances (READ_LAT=1/RSP_DEPTH=2 and READ_LAT=2/RSP_DEPTH=3)
// each behind a behavioural SRAM, checked against a transaction-level memory and response model.
module tb_sram_port_adapter;

    logic clk = 1'b0;
    logic rst_n;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [9:0]  req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [0:0]  req_wuser [2];
    logic [7:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic [0:0]  rsp_ruser [2];
    logic        sram_req  [2];
    logic        sram_we   [2];
    logic [9:0]  sram_addr [2];
    logic [63:0] sram_wdata[2];
    logic [0:0]  sram_wuser[2];
    logic [7:0]  sram_be   [2];
    logic [63:0] sram_rdata[2];
    logic [0:0]  sram_ruser[2];

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [63:0] mem  [1024];
        logic [0:0]  umem [1024];
        logic [64:0] rd1;
        logic [64:0] rd2;

        sram_port_adapter #(
            .DATA_WIDTH(64), .USER_WIDTH(1), .NUM_WORDS(1024),
            .READ_LAT(g == 0 ? 1 : 2), .RSP_DEPTH(g == 0 ? 2 : 3)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]), .req_we_i(req_we[g]),
            .req_addr_i(req_addr[g]), .req_wdata_i(req_wdata[g]), .req_wuser_i(req_wuser[g]),
            .req_be_i(req_be[g]),
            .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
            .rsp_rdata_o(rsp_rdata[g]), .rsp_ruser_o(rsp_ruser[g]),
            .sram_req_o(sram_req[g]), .sram_we_o(sram_we[g]), .sram_addr_o(sram_addr[g]),
            .sram_wdata_o(sram_wdata[g]), .sram_wuser_o(sram_wuser[g]), .sram_be_o(sram_be[g]),
            .sram_rdata_i(sram_rdata[g]), .sram_ruser_i(sram_ruser[g])
        );

        always @(posedge clk) begin
            rd2 <= rd1;
            if (sram_req[g]) begin
                if (sram_we[g]) begin
                    for (int b = 0; b < 8; b++)
                        if (sram_be[g][b]) mem[sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
                    umem[sram_addr[g]] <= sram_wuser[g];
                end else begin
                    rd1 <= {umem[sram_addr[g]], mem[sram_addr[g]]};
                end
            end
        end
        assign {sram_ruser[g], sram_rdata[g]} = (g == 0) ? rd1 : rd2;
    end

    // Reference model: memory image, expected responses in accept order, observed pops.
    logic [63:0] mmem    [2][1024];
    logic [0:0]  muser   [2][1024];
    logic [64:0] exp_dat [2][256];
    int          exp_cyc [2][256];
    int          exp_n   [2];
    logic [64:0] obs_dat [2][256];
    int          obs_cyc [2][256];
    int          obs_n   [2];
    int          outstanding [2];
    int          max_out [2];
    int          sreq_n  [2];
    int          stall_n [2];
    bit          hold    [2];
    logic [64:0] hold_dat[2];
    int          viol;
    int          cyc;
    int          errors;
    int          checks;

    function automatic int dep(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic drive(input int d, input bit v, input bit we, input int addr,
                         input logic [63:0] wd, input logic [7:0] be);
        req_valid[d] = v;
        req_we[d]    = we;
        req_addr[d]  = 10'(addr);
        req_wdata[d] = wd;
        req_be[d]    = be;
        req_wuser[d] = 1'($urandom_range(0, 1));
    endtask

    // Observe one cycle for both instances, update the model, then advance to the next cycle.
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            bit pop;
            bit acc;
            int occ;
            pop = rsp_valid[d] && rsp_ready[d];
            acc = req_valid[d] && req_ready[d];
            occ = outstanding[d] - (pop ? 1 : 0);
            if (req_ready[d] !== (occ < dep(d))) viol++;
            if (sram_req[d] !== acc) viol++;
            if (sram_req[d] && !req_we[d] && sram_be[d] !== 8'h00) viol++;
            if (hold[d] && (rsp_valid[d] !== 1'b1 || {rsp_ruser[d], rsp_rdata[d]} !== hold_dat[d])) viol++;
            hold[d]     = rsp_valid[d] && !rsp_ready[d];
            hold_dat[d] = {rsp_ruser[d], rsp_rdata[d]};
            if (sram_req[d]) sreq_n[d]++;
            if (req_valid[d] && !req_ready[d]) stall_n[d]++;
            if (pop) begin
                obs_dat[d][obs_n[d]] = {rsp_ruser[d], rsp_rdata[d]};
                obs_cyc[d][obs_n[d]] = cyc;
                obs_n[d]++;
                if (outstanding[d] > 0) outstanding[d]--;
            end
            if (acc) begin
                if (req_we[d]) begin
                    for (int b = 0; b < 8; b++)
                        if (req_be[d][b]) mmem[d][req_addr[d]][b*8 +: 8] = req_wdata[d][b*8 +: 8];
                    muser[d][req_addr[d]] = req_wuser[d];
                end else begin
                    exp_dat[d][exp_n[d]] = {muser[d][req_addr[d]], mmem[d][req_addr[d]]};
                    exp_cyc[d][exp_n[d]] = cyc;
                    exp_n[d]++;
                    outstanding[d]++;
                end
            end
            if (outstanding[d] > max_out[d]) max_out[d] = outstanding[d];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (n) step();
    endtask

    task automatic fill(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, 1'b1, i, {$urandom, $urandom}, 8'hFF);
            step();
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); end
            checks++; if (rsp_rdata[d] !== 64'h0) begin errors++; $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); end
            checks++; if (rsp_ruser[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_ruser[%0d]: got %b want 0", d, rsp_ruser[d]); end
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b want 1", d, req_ready[d]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int o0 = obs_n[0];
        int e0 = exp_n[0];
        int s0 = sreq_n[0];
        rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        step();
        drive(0, 1'b1, 1'b0, 5, {$urandom, $urandom}, 8'($urandom));
        step();
        idle(4);
        checks++; if (obs_n[0] - o0 !== 1) begin errors++; $display("FAIL wr_rd_rsp_count: got %0d want 1", obs_n[0] - o0); end
        checks++; if (sreq_n[0] - s0 !== 2) begin errors++; $display("FAIL wr_rd_sram_req_count: got %0d want 2", sreq_n[0] - s0); end
        checks++; if (obs_dat[0][o0][63:0] !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL wr_rd_data: got %h want deadbeefcafef00d", obs_dat[0][o0][63:0]); end
        checks++; if (obs_cyc[0][o0] - exp_cyc[0][e0] !== 2) begin errors++; $display("FAIL wr_rd_latency: got %0d want 2", obs_cyc[0][o0] - exp_cyc[0][e0]); end
    endtask

    task automatic test_back_to_back();
        int o0 = obs_n[0];
        int e0 = exp_n[0];
        int st = stall_n[0];
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b0, $urandom_range(0, 15), {$urandom, $urandom}, 8'($urandom));
            step();
        end
        idle(5);
        checks++; if (stall_n[0] - st !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stall_n[0] - st); end
        checks++; if (obs_n[0] - o0 !== 8) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 8", obs_n[0] - o0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs_dat[0][o0+i] !== exp_dat[0][e0+i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, obs_dat[0][o0+i], exp_dat[0][e0+i]); end
        end
        for (int i = 1; i < 8; i++) begin
            checks++; if (obs_cyc[0][o0+i] - obs_cyc[0][o0+i-1] !== 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want 1", i, obs_cyc[0][o0+i] - obs_cyc[0][o0+i-1]); end
        end
    endtask

    task automatic test_backpressure();
        int o0 = obs_n[0];
        int e0 = exp_n[0];
        int s0 = sreq_n[0];
        rsp_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, $urandom_range(0, 15), {$urandom, $urandom}, 8'($urandom));
            step();
        end
        #1;
        checks++; if (exp_n[0] - e0 !== 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", exp_n[0] - e0); end
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b want 0", req_ready[0]); end
        checks++; if (sram_req[0] !== 1'b0) begin errors++; $display("FAIL bp_sram_req: got %b want 0", sram_req[0]); end
        checks++; if (sreq_n[0] - s0 !== 2) begin errors++; $display("FAIL bp_sram_req_count: got %0d want 2", sreq_n[0] - s0); end
        rsp_ready[0] = 1'b1;
        idle(6);
        checks++; if (obs_n[0] - o0 !== 2) begin errors++; $display("FAIL bp_rsp_count: got %0d want 2", obs_n[0] - o0); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (obs_dat[0][o0+i] !== exp_dat[0][e0+i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_dat[0][o0+i], exp_dat[0][e0+i]); end
        end
    endtask

    task automatic test_toggle();
        int o1 = obs_n[1];
        int e1 = exp_n[1];
        int k  = 0;
        max_out[1] = outstanding[1];
        for (int c = 0; c < 40 && (k < 4 || obs_n[1] - o1 < 4); c++) begin
            rsp_ready[1] = (c % 2) == 1;
            if (k < 4) drive(1, 1'b1, 1'b0, k, {$urandom, $urandom}, 8'($urandom));
            else req_valid[1] = 1'b0;
            step();
            k = exp_n[1] - e1;
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        checks++; if (obs_n[1] - o1 !== 4) begin errors++; $display("FAIL tog_rsp_count: got %0d want 4", obs_n[1] - o1); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_dat[1][o1+i] !== {muser[1][i], mmem[1][i]}) begin errors++; $display("FAIL tog_data[%0d]: got %h want %h", i, obs_dat[1][o1+i], {muser[1][i], mmem[1][i]}); end
        end
        checks++; if (max_out[1] > 3) begin errors++; $display("FAIL tog_max_outstanding: got %0d want <=3", max_out[1]); end
    endtask

    task automatic test_reset_mid();
        int o0;
        rsp_ready[0] = 1'b0;
        drive(0, 1'b1, 1'b0, 1, {$urandom, $urandom}, 8'h00);
        step();
        drive(0, 1'b1, 1'b0, 2, {$urandom, $urandom}, 8'h00);
        step();
        req_valid[0] = 1'b0;
        #1;
        checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", rsp_valid[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rstmid_valid_in_reset: got %b want 0", rsp_valid[0]); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            outstanding[d] = 0;
            exp_n[d]       = obs_n[d];
            hold[d]        = 1'b0;
        end
        o0 = obs_n[0];
        rsp_ready[0] = 1'b1;
        idle(6);
        checks++; if (obs_n[0] - o0 !== 0) begin errors++; $display("FAIL rstmid_stale_rsp: got %0d want 0", obs_n[0] - o0); end
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready[0]); end
    endtask

    task automatic test_partial_write();
        int o0 = obs_n[0];
        int e0 = exp_n[0];
        logic [63:0] nd;
        nd = {$urandom, $urandom};
        rsp_ready[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        drive(0, 1'b1, 1'b1, 9, nd, 8'h0F);
        step();
        drive(0, 1'b1, 1'b0, 9, {$urandom, $urandom}, 8'($urandom));
        step();
        idle(5);
        checks++; if (obs_n[0] - o0 !== 1) begin errors++; $display("FAIL pw_rsp_count: got %0d want 1", obs_n[0] - o0); end
        checks++; if (obs_dat[0][o0][63:0] !== {32'hFFFF_FFFF, nd[31:0]}) begin errors++; $display("FAIL pw_data: got %h want %h", obs_dat[0][o0][63:0], {32'hFFFF_FFFF, nd[31:0]}); end
        checks++; if (obs_dat[0][o0] !== exp_dat[0][e0]) begin errors++; $display("FAIL pw_model: got %h want %h", obs_dat[0][o0], exp_dat[0][e0]); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        viol   = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 0, 64'h0, 8'h00);
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        fill(0, 16);
        fill(1, 4);
        idle(2);
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_partial_write();
        checks++; if (viol !== 0) begin errors++; $display("FAIL cycle_rules: got %0d violations want 0", viol); end
        for (int d = 0; d < 2; d++) begin
            checks++; if (obs_n[d] !== exp_n[d]) begin errors++; $display("FAIL rsp_total[%0d]: got %0d want %0d", d, obs_n[d], exp_n[d]); end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
